// File: rtl/muldiv_pkg.sv
// Shared types, constants and op-decode helpers for the RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } md_state_e;

  localparam int unsigned MD_ITERS  = 32;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

  function automatic logic is_div(md_op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem(md_op_e op);
    return (op == REM) || (op == REMU);
  endfunction

  function automatic logic a_signed(md_op_e op);
    return (op == MUL) || (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
  endfunction

  function automatic logic b_signed(md_op_e op);
    return (op == MUL) || (op == MULH) || (op == DIV) || (op == REM);
  endfunction

endpackage

// File: rtl/muldiv_abs.sv
// Conditional two's-complement negate: y = neg ? -x : x.
module muldiv_abs #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);

  // Negate on request, pass through otherwise.
  always_comb begin
    y = neg ? (~x + W'(1)) : x;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring divide
// on operand magnitudes, with a final sign-fix cycle. Fixed 33-clock latency.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ITERS = MD_ITERS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned       CNT_W    = $clog2(ITERS);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(ITERS - 1);

  md_state_e        state, state_nx;
  md_op_e           op_in, op_q;
  logic             sa, sb, b_zero;
  logic [CNT_W-1:0] count;
  // acc_hi: product high / partial remainder; acc_lo: multiplier->product low /
  // dividend->quotient; opnd: multiplicand or divisor magnitude.
  logic [31:0]      acc_hi, acc_lo, opnd;
  logic             a_neg, b_neg;
  logic [31:0]      abs_a, abs_b;
  logic [32:0]      add_x, add_y;
  logic             add_cin;
  logic [33:0]      add_sum;
  logic [63:0]      fix_in, fix_out;
  logic             fix_neg;
  logic [31:0]      fix_word;

  assign op_in = md_op_e'(op);
  assign busy  = (state != IDLE);

  // Operand sign flags for the incoming request.
  always_comb begin
    a_neg = a[31] & a_signed(op_in);
    b_neg = b[31] & b_signed(op_in);
  end

  muldiv_abs #(.W(32)) u_abs_a (.x(a), .neg(a_neg), .y(abs_a));
  muldiv_abs #(.W(32)) u_abs_b (.x(b), .neg(b_neg), .y(abs_b));

  // Shared adder: multiply accumulate, or trial subtract (carry out = no borrow).
  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_cin = 1'b0;
    if (is_div(op_q)) begin
      add_x   = {acc_hi, acc_lo[31]};
      add_y   = ~{1'b0, opnd};
      add_cin = 1'b1;
    end else begin
      add_x   = {1'b0, acc_hi};
      add_y   = acc_lo[0] ? {1'b0, opnd} : '0;
    end
    add_sum = {1'b0, add_x} + {1'b0, add_y} + 34'(add_cin);
  end

  // Sign-fix input selection; divides go through the low half of the 64-bit negator.
  always_comb begin
    fix_in  = {acc_hi, acc_lo};
    fix_neg = sa ^ sb;
    if (is_div(op_q)) begin
      if (is_rem(op_q)) begin
        fix_in  = {32'h0, acc_hi};
        fix_neg = sa;
      end else begin
        fix_in  = {32'h0, (b_zero ? DIV0_QUOT : acc_lo)};
        fix_neg = (sa ^ sb) & ~b_zero;
      end
    end
  end

  muldiv_abs #(.W(64)) u_fix (.x(fix_in), .neg(fix_neg), .y(fix_out));

  // Word select: MUL and all divides take the low word, MULH* the high word.
  always_comb begin
    fix_word = ((op_q == MUL) || is_div(op_q)) ? fix_out[31:0] : fix_out[63:32];
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CALC;
      CALC:    if (count == '0) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Datapath: latch operands, iterate, then register the signed result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= MUL;
      sa     <= 1'b0;
      sb     <= 1'b0;
      b_zero <= 1'b0;
      count  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op_in;
            sa     <= a_neg;
            sb     <= b_neg;
            b_zero <= (b == '0);
            count  <= CNT_INIT;
            acc_hi <= '0;
            if (is_div(op_in)) begin
              acc_lo <= abs_a;
              opnd   <= abs_b;
            end else begin
              acc_lo <= abs_b;
              opnd   <= abs_a;
            end
          end
        end
        CALC: begin
          if (count != '0) count <= count - CNT_W'(1);
          if (is_div(op_q)) begin
            acc_lo <= {acc_lo[30:0], add_sum[33]};
            acc_hi <= add_sum[33] ? add_sum[31:0] : {acc_hi[30:0], acc_lo[31]};
          end else begin
            acc_hi <= add_sum[32:1];
            acc_lo <= {add_sum[0], acc_lo[31:1]};
          end
        end
        FIX: begin
          result <= fix_word;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: cycle-level reference model plus directed cases.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;
  int ndone = 0;

  muldiv_unit #(.XLEN(32), .ITERS(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Architectural RV32M result from plain integer arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    longint      sx, sy, ux, uy;
    logic [63:0] p;
    int          ix, iy;
    sx = longint'(signed'(x));
    sy = longint'(signed'(y));
    ux = longint'({32'h0, x});
    uy = longint'({32'h0, y});
    ix = signed'(x);
    iy = signed'(y);
    p  = '0;
    case (o)
      3'd0: begin p = 64'(sx * sy); return p[31:0]; end
      3'd1: begin p = 64'(sx * sy); return p[63:32]; end
      3'd2: begin p = 64'(sx * uy); return p[63:32]; end
      3'd3: begin p = {32'h0, x} * {32'h0, y}; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ix / iy);
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ix % iy);
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  // Cycle model: a request seen while idle yields done/result 33 clocks later.
  int          rem_cyc = 0;
  logic        exp_done = 1'b0;
  logic [31:0] exp_res = '0;
  logic [31:0] pend_res = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_cyc  <= 0;
      exp_done <= 1'b0;
      exp_res  <= '0;
    end else if (rem_cyc != 0) begin
      rem_cyc <= rem_cyc - 1;
      if (rem_cyc == 1) begin
        exp_done <= 1'b1;
        exp_res  <= pend_res;
      end else begin
        exp_done <= 1'b0;
      end
    end else begin
      exp_done <= 1'b0;
      if (start) begin
        rem_cyc  <= 33;
        pend_res <= ref_result(op, a, b);
      end
    end
  end

  // Compare DUT against the model every cycle.
  always @(negedge clk) begin
    if (!rst && cmp_en) begin
      check("busy", 32'(busy), 32'(rem_cyc != 0));
      check("done", 32'(done), 32'(exp_done));
      check("result", result, exp_res);
      if (done) ndone++;
    end
  end

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic drive_start(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
  endtask

  // Wait for done (bounded); k = negedges since the start-drive edge.
  task automatic wait_done(output int k, output int nb);
    k = 1;
    nb = busy ? 1 : 0;
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
      if (busy) nb++;
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] expv);
    int k, nb;
    @(negedge clk);
    for (int i = 0; i < 50 && busy; i++) @(negedge clk);
    drive_start(o, x, y);
    wait_done(k, nb);
    check({name, "_done_seen"}, 32'(done), 32'd1);
    check({name, "_latency"}, 32'(k - 1), 32'd33);
    check({name, "_busy_cycles"}, 32'(nb), 32'd33);
    check({name, "_result"}, result, expv);
  endtask

  initial begin
    int k, nb, seen, n0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'h0);
    rst = 1'b0;
    cmp_en = 1'b1;

    // Pin the reference model against hand-worked values
    check("model_mul", ref_result(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    check("model_div", ref_result(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    check("model_rem", ref_result(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    check("model_mulhsu", ref_result(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);

    // Directed arithmetic cases
    run_op("mul_neg", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_op("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_op("divu", 3'd5, 32'd100, 32'd7, 32'd14);
    run_op("remu", 3'd7, 32'd100, 32'd7, 32'd2);
    run_op("divu_by0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_op("remu_by0", 3'd7, 32'd5, 32'd0, 32'd5);
    run_op("div_by0_neg", 3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
    run_op("rem_by0_neg", 3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

    // Starts while busy are ignored; start in the done cycle is accepted
    @(negedge clk);
    drive_start(3'd0, 32'd6, 32'd7);
    k = 1;
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
      start = (k == 5 || k == 20);
      op = 3'd5; a = 32'd1000; b = 32'd3;
    end
    start = 1'b0;
    check("busy_start_latency", 32'(k - 1), 32'd33);
    check("busy_start_result", result, 32'd42);
    drive_start(3'd5, 32'd100, 32'd7);
    wait_done(k, nb);
    check("b2b_latency", 32'(k - 1), 32'd33);
    check("b2b_result", result, 32'd14);

    // Asynchronous reset mid-iteration
    @(negedge clk);
    drive_start(3'd0, 32'h1234_5678, 32'd9);
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("rst_no_done", 32'(seen), 32'd0);
    run_op("mul_after_rst", 3'd0, 32'd3, 32'd4, 32'd12);

    // Random traffic, including starts while busy
    n0 = ndone;
    for (int c = 0; c < 70000 && (ndone - n0) < 1500; c++) begin
      @(negedge clk);
      start = ($urandom_range(0, 1) == 0);
      op = 3'($urandom_range(0, 7));
      a = rnd_word();
      b = rnd_word();
    end
    start = 1'b0;
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("random_ops_completed", 32'((ndone - n0) >= 1500), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
